// File: rtl/fetch_stage.sv
// RV32I instruction-fetch front end: fetch PC, one-deep imem request pipe, instr/PC FIFO, redirect flush.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counter outputs.
module fetch_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic          push, pop, issue;
  logic [CW:0]   used;

  always_comb begin
    pop  = (count_q != '0) && out_ready && !redirect_valid;
    push = inflight_q && !redirect_valid;
    // A pop this cycle hands its slot straight back to the issue credit.
    used  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue = reset && !redirect_valid && (32'(used) < DEPTH);

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        instr_q[wr_ptr_q] <= imem_rdata;
        pc_q[wr_ptr_q]    <= inflight_pc_q;
      end
    end
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = instr_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop)                     perf_fetched_q <= perf_fetched_q + 32'd1;
      if (out_valid && !out_ready) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model, random ready/redirect traffic,
// plus a second instance with a high RESET_PC to watch the 32-bit PC wrap.
module tb_fetch_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, out_valid, out_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
  logic        imem_req_hi, out_valid_hi;
  logic [31:0] imem_addr_hi, imem_rdata_hi, out_instr_hi, out_pc_hi;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_fetched_hi, perf_stall_hi;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(HI_PC)) u_dut_hi (
    .clk(clk), .reset(reset),
    .imem_req(imem_req_hi), .imem_addr(imem_addr_hi), .imem_rdata(imem_rdata_hi),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid_hi), .out_ready(1'b1), .out_instr(out_instr_hi), .out_pc(out_pc_hi)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched_hi), .perf_stall(perf_stall_hi)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
  endfunction

  // Reference model: fetch PC, one outstanding request, FIFO of {pc, instr}
  logic [31:0] m_pc, m_infl_pc, m_fetched, m_stall;
  bit          m_infl;
  logic [63:0] m_q[$];
  // Memory stubs: remember last request to answer it next cycle
  bit          mem_pend, hi_pend;
  logic [31:0] mem_addr, hi_addr;
  int          hi_cyc;
  bit          redir_watch;
  logic [31:0] redir_exp;

  task automatic model_reset();
    m_pc = 32'h0; m_infl = 0; m_infl_pc = 32'h0; m_q.delete();
    m_fetched = 0; m_stall = 0;
    mem_pend = 0; hi_pend = 0; hi_cyc = 0;
  endtask

  task automatic step();
    bit exp_valid, pop, exp_req;
    imem_rdata    = mem_pend ? word_of(mem_addr) : $urandom;
    imem_rdata_hi = hi_pend  ? word_of(hi_addr)  : $urandom;
    @(negedge clk);
    exp_valid = (m_q.size() != 0);
    pop       = exp_valid && out_ready && !redirect_valid;
    exp_req   = !redirect_valid && (m_q.size() + int'(m_infl) - int'(pop) < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk("out_pc", out_pc, m_q[0][63:32]);
      chk("out_instr", out_instr, m_q[0][31:0]);
    end
    if (redir_watch && out_valid) begin
      chk("redir_first_pc", out_pc, redir_exp);
      redir_watch = 0;
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
`endif
    chk("hi_valid", {31'b0, out_valid_hi}, (hi_cyc >= 2) ? 32'd1 : 32'd0);
    if (hi_cyc >= 2) begin
      chk("hi_pc", out_pc_hi, HI_PC + 32'(4 * (hi_cyc - 2)));
      chk("hi_instr", out_instr_hi, word_of(HI_PC + 32'(4 * (hi_cyc - 2))));
    end

    mem_pend = imem_req;    mem_addr = imem_addr;
    hi_pend  = imem_req_hi; hi_addr  = imem_addr_hi;
    if (pop) m_fetched++;
    if (exp_valid && !out_ready) m_stall++;
    if (redirect_valid) begin
      m_q.delete();
      m_infl = 0;
      m_pc   = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back({m_infl_pc, word_of(m_infl_pc)});
      m_infl = exp_req;
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    hi_cyc++;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; asserts reset mid-cycle and checks outputs drop at once.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_hi_valid", {31'b0, out_valid_hi}, 32'd0);
    imem_rdata = $urandom;
    @(posedge clk);
    imem_rdata = $urandom;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rdata = 32'h0; imem_rdata_hi = 32'h0;
    redir_watch = 0; redir_exp = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_imem_req", {31'b0, imem_req}, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    reset = 1'b1;

    // Streaming with decode always ready
    repeat (12) step();
    // Let the FIFO partially fill, then reset mid-stream
    out_ready = 1'b0;
    repeat (2) step();
    mid_reset();

    // Backpressure from reset: fill to DEPTH, then drain in order
    out_ready = 1'b0;
    repeat (8) step();
    out_ready = 1'b1;
    repeat (8) step();
    mid_reset();

    // Redirect with two buffered entries and one in flight
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    step();
    redirect_valid = 1'b0;
    redir_watch = 1;
    redir_exp = 32'h0000_0040;
    repeat (8) step();
    chk("redir_seen", {31'b0, redir_watch}, 32'd0);
    redir_watch = 0;

    // Random traffic: varying ready pressure, sporadic and back-to-back redirects
    for (int blk = 0; blk < 12; blk++) begin
      int bias;
      bias = int'($urandom_range(0, 4));
      for (int c = 0; c < 50; c++) begin
        out_ready      = (int'($urandom_range(0, 3)) < bias);
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_pc    = $urandom;
        step();
      end
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end for the single-issue RV32I core.
- Owns the architectural fetch PC, issues word requests to the instruction memory, and buffers returned instructions with their PCs in a small FIFO.
- Hands instruction/PC pairs downstream to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch PC after reset (word aligned).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  32  byte address of requested word, bits [1:0] always 0.
- imem_rdata  input  32  instruction word, valid exactly one cycle after the cycle imem_req=1.
- redirect_valid  input  1  redirect fetch to redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0).
- out_valid  output  1  out_instr/out_pc hold a valid entry.
- out_ready  input  1  decode accepts the entry.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  PC of out_instr.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; in-flight flag cleared.
  - imem_req=0, out_valid=0, out_instr=0, out_pc=0.
- Issue:
  - imem_req = !redirect_valid && (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - On issue, fetch_pc <= fetch_pc+4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000).
  - inflight <= 1 and the issued PC is latched; otherwise inflight <= 0.
- Return: in the cycle after an issue, imem_rdata and the latched PC are pushed into the FIFO, unless a redirect occurs in that cycle.
- Latency: first edge after reset release = cycle 0 (req at RESET_PC); push at end of cycle 1; out_valid=1 in cycle 2. Steady state: one instruction per cycle while out_ready=1.
- Output:
  - out_valid = (count != 0).
  - out_instr/out_pc = head entry.
  - Pop on out_valid && out_ready && !redirect_valid.
  - out_instr/out_pc hold their value while out_valid=1 && out_ready=0.
- Credit rule: count + inflight never exceeds DEPTH, so a push never meets a full FIFO.
  - Simultaneous push and pop keeps count unchanged.
  - Full with out_ready=0: imem_req=0 until a pop frees a slot.
  - A pop frees a credit the same cycle: imem_req may assert in the cycle of the pop.
- Redirect (redirect_valid=1), priority over everything:
  - No request issued that cycle.
  - At the edge: FIFO flushed (count=0), in-flight return discarded, fetch_pc <= {redirect_pc[31:2],2'b00}.
  - A handshake coincident with redirect_valid is void; decode must not consume it.
  - First request at the new PC in the following cycle; its instruction reaches out_valid two cycles after that.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: immediate return to reset state. Any imem_rdata arriving afterwards is ignored.
- count width = $clog2(DEPTH)+1; pointers wrap modulo DEPTH.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32) and perf_stall (32), both reset to 0 and wrapping at 2^32.
  - perf_fetched increments per accepted pop.
  - perf_stall increments each cycle out_valid && !out_ready.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Release reset, RESET_PC=0, out_ready=1, imem returns addr-tagged words -> imem_addr 0,4,8,… one per cycle; out_valid first high cycle 2 with out_pc=0, then out_pc increments by 4 every cycle, no gaps.
- out_ready=0 after reset -> exactly DEPTH=4 entries buffered (out_pc 0 held), imem_req low from cycle 4. Then out_ready=1 -> pops in order 0,4,8,C,10 with no loss or duplicate.
- Streaming, pulse redirect_valid with redirect_pc=0x0000_0043 while FIFO holds 2 entries and 1 in flight -> next out_valid entry has out_pc=0x40. No stale PC (pre-redirect values) ever presented after the redirect edge.
- RESET_PC=0xFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert reset mid-stream with FIFO partly full -> out_valid and imem_req drop immediately (asynchronously). After release, fetch restarts at RESET_PC with the cycle-2 latency.
- With FETCH_PERF_EN, 10 pops and 3 stalled cycles -> perf_fetched=10, perf_stall=3. Without the macro, the build elaborates with no perf_* ports.
